song_sequencer_pwm: RTL
=======================

// Module: song_sequencer_pwm
// PURPOSE
//  Plays a song from a note table as PWM audio, clocked by the 50 MHz clock from the board PLL.
//  - Reads 32-bit entries from a synchronous ROM; each entry is a tone half-period and a duration.
//  - Generates the square-wave tone and gates it with an 8-bit PWM carrier for volume.
//  - pwm_out drives the speaker/RC-filter pin directly.
// PARAMETERS
//  CLK_FREQ  50_000_000  clk frequency in Hz; MS_DIV = CLK_FREQ/1000 cycles per ms tick
//  ADDR_W    8           note table address width (max 2^ADDR_W entries)
// PORTS
//  clk       in   1       system clock (PLL output)
//  rst_n     in   1       synchronous reset, active low
//  start     in   1       1-cycle pulse: begin playing from entry 0 (ignored while busy)
//  stop      in   1       abort playback, return to IDLE
//  loop_en   in   1       1: restart at entry 0 on end-of-song
//  volume    in   8       PWM duty, 0 = silent, 255 = 255/256
//  rom_addr  out  ADDR_W  note table read address (registered)
//  rom_data  in   32      entry: [31:12] half_period (clk cycles, 0 = rest), [11:0] duration_ms (0 = end)
//  pwm_out   out  1       audio PWM output (registered)
//  busy      out  1       high in any state other than IDLE
//  done      out  1       1-cycle pulse on natural end-of-song (not on stop)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, rom_addr=0, pwm_out=0, busy=0, done=0,
//   tone_phase=0, all counters 0. Reset mid-note aborts immediately.
//  ROM contract: synchronous read, rom_data valid one cycle after rom_addr is presented.
//  FSM states: IDLE, FETCH, LATCH, PLAY.
//  - IDLE: rom_addr=0.
//     start=1 & stop=0 -> FETCH.
//  - FETCH: rom_addr is held for one cycle.
//     -> LATCH.
//  - LATCH: rom_data is sampled.
//     duration==0 (end marker): if loop_en=1 and rom_addr!=0, set rom_addr=0 and go to FETCH.
//      Otherwise go to IDLE and pulse done for 1 cycle.
//     duration!=0: load hp=half_period and dur_left=duration; clear tone_cnt, ms_cnt, tone_phase.
//      -> PLAY.
//  - PLAY: tone_cnt counts 0..hp-1; on wrap to 0, tone_phase toggles.
//     hp==0 (rest): tone_phase stays 0.
//     ms_cnt counts 0..MS_DIV-1; each wrap decrements dur_left.
//     When the wrap occurs with dur_left==1, rom_addr+1 (wraps to 0 modulo 2^ADDR_W) -> FETCH.
//  - Note timing: note length = duration*MS_DIV cycles in PLAY, plus 2 gap cycles (FETCH+LATCH).
//     pwm_out is 0 during the gap cycles.
//  - stop=1 in any state: -> IDLE on that edge; pwm_out=0 next cycle; done not pulsed.
//     stop wins over simultaneous start.
//  - start while busy: ignored.
//     start together with the done cycle: ignored (state is IDLE only the cycle after).
//  - PWM: pwm_cnt is an 8-bit free-running counter (runs in all states, reset to 0).
//     pwm_out <= (state==PLAY) & tone_phase & (pwm_cnt < volume).
//     volume is sampled every cycle, no latching.
//  - Widths: tone_cnt 20 bit, dur_left 12 bit, ms_cnt $clog2(MS_DIV) bit.
//     No counter overflows for legal field values.
//  - Table with no end marker: playback wraps through all 2^ADDR_W entries indefinitely until stop.
// TESTING (CLK_FREQ=10_000 -> MS_DIV=10, ADDR_W=4, ROM model with 1-cycle latency)
//  1. Reset held 3 cycles with start=1
//     -> pwm_out=0, busy=0, rom_addr=0, done=0 throughout.
//  2. ROM[0]={hp=4,dur=2}, ROM[1]={0,0}, volume=255, start pulse
//     -> busy rises; PLAY for 20 cycles; tone_phase period 8 cycles.
//     -> rom_addr goes 0->1; done pulses once; busy falls; total 24 cycles after start.
//  3. Same table, volume=0
//     -> pwm_out stays 0 throughout, timing identical to scenario 2.
//     Then volume=128 -> pwm_out high duty ~50% within tone_phase high windows.
//  4. ROM[0]={hp=0,dur=3} (rest), ROM[1]={0,0}
//     -> pwm_out=0 for the full 30 PLAY cycles; done pulses.
//  5. loop_en=1, ROM[0]={hp=3,dur=1}, ROM[1]={0,0}
//     -> rom_addr sequence 0,1,0,1...; no done pulse.
//     Then stop -> IDLE next cycle, busy=0, pwm_out=0.
//  6. start and stop asserted in the same cycle from IDLE -> remains IDLE.
//     start pulse while in PLAY -> ignored, rom_addr unchanged.
//     rst_n=0 mid-note -> all outputs at reset values next edge.

Source files
------------

// File: rtl/song_sequencer_pwm.sv
// Note-table song player: fetches {half_period, duration_ms} entries from a
// synchronous ROM and plays each as a square-wave tone gated by an 8-bit PWM carrier.
module song_sequencer_pwm #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [7:0]        volume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              pwm_out,
    output logic              busy,
    output logic              done
);

    localparam int MS_DIV = CLK_FREQ / 1000;
    localparam int MS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [19:0]       hp_q, hp_d;
    logic [19:0]       tone_cnt_q, tone_cnt_d;
    logic [11:0]       dur_left_q, dur_left_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic              tone_phase_q, tone_phase_d;
    logic [7:0]        pwm_cnt_q, pwm_cnt_d;
    logic              pwm_out_q, pwm_out_d;
    logic              done_d;

    logic [19:0] rom_hp;
    logic [11:0] rom_dur;

    assign rom_hp  = rom_data[31:12];
    assign rom_dur = rom_data[11:0];

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        hp_d         = hp_q;
        tone_cnt_d   = tone_cnt_q;
        dur_left_d   = dur_left_q;
        ms_cnt_d     = ms_cnt_q;
        tone_phase_d = tone_phase_q;
        pwm_cnt_d    = pwm_cnt_q + 8'd1;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                rom_addr_d = '0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                if (rom_dur == 12'd0) begin
                    // Looping from entry 0 back to itself would spin forever on an empty song.
                    if (loop_en && (rom_addr_q != '0)) begin
                        rom_addr_d = '0;
                        state_d    = S_FETCH;
                    end else begin
                        rom_addr_d = '0;
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                    end
                end else begin
                    hp_d         = rom_hp;
                    dur_left_d   = rom_dur;
                    tone_cnt_d   = '0;
                    ms_cnt_d     = '0;
                    tone_phase_d = 1'b0;
                    state_d      = S_PLAY;
                end
            end
            S_PLAY: begin
                if (hp_q != 20'd0) begin
                    if (tone_cnt_q == hp_q - 20'd1) begin
                        tone_cnt_d   = '0;
                        tone_phase_d = ~tone_phase_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + 20'd1;
                    end
                end
                if (ms_cnt_q == MS_LAST) begin
                    ms_cnt_d   = '0;
                    dur_left_d = dur_left_q - 12'd1;
                    if (dur_left_q == 12'd1) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = S_FETCH;
                    end
                end else begin
                    ms_cnt_d = ms_cnt_q + MS_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop) begin
            state_d    = S_IDLE;
            rom_addr_d = '0;
            done_d     = 1'b0;
        end

        // Judged on next-cycle state so the output is silent exactly in non-PLAY cycles.
        pwm_out_d = (state_d == S_PLAY) && tone_phase_d && (pwm_cnt_q < volume);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            hp_q         <= '0;
            tone_cnt_q   <= '0;
            dur_left_q   <= '0;
            ms_cnt_q     <= '0;
            tone_phase_q <= 1'b0;
            pwm_cnt_q    <= '0;
            pwm_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            hp_q         <= hp_d;
            tone_cnt_q   <= tone_cnt_d;
            dur_left_q   <= dur_left_d;
            ms_cnt_q     <= ms_cnt_d;
            tone_phase_q <= tone_phase_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_out_q    <= pwm_out_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign pwm_out  = pwm_out_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_d;

endmodule
